sipo_rx: RTL and testbench
==========================

SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 The module SHALL have parameter W, default 4, giving the data width in bits per frame (legal range 2..16).
REQ-002 The module SHALL have port clk, input, 1, rising-edge clock.
REQ-003 The module SHALL have port rst_, input, 1, asynchronous active-low reset.
REQ-004 The module SHALL have port si, input, 1, serial data in (LSB-first).
REQ-005 The module SHALL have port sv, input, 1, serial-bit-valid; si is sampled only on edges where sv=1.
REQ-006 The module SHALL have port q, output, W, received parallel word.
REQ-007 The module SHALL have port q_valid, output, 1, q holds an unconsumed word.
REQ-008 The module SHALL have port q_ready, input, 1, consumer accepts q when q_valid=1 and q_ready=1 on the same edge.
REQ-009 The module SHALL have port ovr, output, 1, one-cycle pulse when a completed frame is dropped due to a full output.
REQ-010 The module SHALL have port perr, output, 1, one-cycle pulse on parity mismatch (tied 0 when the parity feature is compiled out).

Function
REQ-011 The FSM SHALL have states IDLE, DATA, PAR (parity build only) and a registered output stage; sv=0 SHALL hold state, bit counter and shift register unchanged.
REQ-012 In IDLE, a sample with sv=1, si=1 SHALL be the start bit: go to DATA with bit count 0; sv=1, si=0 SHALL remain in IDLE.
REQ-013 In DATA, each sv=1 sample SHALL shift si into bit position [count] (LSB-first) and increment count; after the W-th bit go to PAR (parity build) or complete the frame (otherwise).
REQ-014 In PAR, one sv=1 sample SHALL be the parity bit; even parity over the W data bits plus parity bit; on match complete the frame, on mismatch pulse perr, drop the frame, return to IDLE.
REQ-015 On frame completion the FSM SHALL return to IDLE; the next frame's start bit is accepted on the immediately following sv=1 sample (no gap required).
REQ-016 On completion, if q_valid=0 or (q_valid=1 and q_ready=1) on that edge, q SHALL load the word and q_valid SHALL be 1 from the next cycle; latency: q_valid rises one clock after the final (data or parity) bit is sampled.
REQ-017 On completion with q_valid=1 and q_ready=0, the frame SHALL be discarded, q and q_valid unchanged, and ovr pulsed for exactly one cycle.
REQ-018 q_valid=1 with q_ready=1 and no completion on that edge SHALL clear q_valid; q SHALL keep its last value.
REQ-019 q SHALL remain stable while q_valid=1 and q_ready=0.
REQ-020 Reception SHALL continue independently of q_ready (one-entry output buffer; the shifter never stalls on back-pressure).

Reset
REQ-021 When rst_=0, the module SHALL asynchronously set FSM=IDLE, count=0, shift register=0, q=0, q_valid=0, ovr=0, perr=0.
REQ-022 Reset mid-frame SHALL discard the partial frame; after release, only a fresh start bit begins a frame.
REQ-023 On release of rst_, the module SHALL run normally from the first rising edge.

Configuration
REQ-024 The parity feature SHALL be controlled by macro SIPO_RX_PARITY_EN.
REQ-025 With SIPO_RX_PARITY_EN defined, the PAR state and the even-parity check SHALL be present; frame = start + W data + parity.
REQ-026 Without SIPO_RX_PARITY_EN, there SHALL be no PAR state, frame = start + W data, and perr SHALL be constant 0.

Structure
REQ-027 Package sipo_rx_pkg SHALL hold the FSM state enum, the default width constant (4) and the counter-width constant ($clog2 of max W).
REQ-028 The valid/ready holding register SHALL be a sub-module named sipo_rx_obuf (load, data, ready in; q, q_valid, ovr out).

Verification (W=4)
REQ-029 The bench SHALL check: sv=1, si sequence 1 (start), 1,0,1,1 -> q=4'hD, q_valid=1 one clock after the last bit; q_ready=1 -> q_valid=0 next cycle.
REQ-030 The bench SHALL check: same frame with sv=0 for 3 cycles inserted between data bits 2 and 3 -> q=4'hD, with latency extended by exactly 3 cycles.
REQ-031 The bench SHALL check: q_ready=0, frames 4'h3 then 4'hA back-to-back -> q stays 4'h3, ovr single pulse at the second completion; then q_ready=1 -> q_valid drops, and the next frame 4'h5 is delivered.
REQ-032 The bench SHALL check: rst_=0 after 2 data bits, then released, then a full frame 4'h6 -> only 4'h6 is delivered, with no stale bits.
REQ-033 The bench SHALL check, in the parity build: frame 4'hD with parity 1 -> delivered; 4'hD with parity 0 -> perr pulse, q_valid stays 0. In the non-parity build: perr is 0 throughout.
REQ-034 The bench SHALL check: completion on the same edge as q_ready=1 with q_valid=1 -> new word loaded, q_valid stays 1, ovr=0.

Source files
------------

// File: rtl/sipo_rx_pkg.sv
// Shared definitions for the serial-in / parallel-out receiver.
// Holds the FSM state enum, the default frame width and the bit-counter width.
// Build option: SIPO_RX_PARITY_EN adds the parity state.
package sipo_rx_pkg;

  localparam int unsigned DefaultW = 4;
  localparam int unsigned MaxW     = 16;
  // Counter only needs to index bit positions 0..MaxW-1.
  localparam int unsigned CntW     = $clog2(MaxW);

`ifdef SIPO_RX_PARITY_EN
  typedef enum logic [1:0] {StIdle, StData, StPar} state_e;
`else
  typedef enum logic [1:0] {StIdle, StData} state_e;
`endif

endpackage

// File: rtl/sipo_rx_obuf.sv
// One-entry valid/ready output holding register.
// Ports: clk, rst_ (async active-low), load/data (completed frame), ready (consumer),
//        q/q_valid (held word), ovr (one-cycle pulse when a load is dropped).
module sipo_rx_obuf #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         load,
  input  logic [W-1:0] data,
  input  logic         ready,
  output logic [W-1:0] q,
  output logic         q_valid,
  output logic         ovr
);

  logic [W-1:0] q_q, q_d;
  logic         valid_q, valid_d;
  logic         ovr_q, ovr_d;

  always_comb begin
    q_d     = q_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (load) begin
      // A word being consumed on this edge frees the slot for the new one.
      if (!valid_q || ready) begin
        q_d     = data;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      q_q     <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      q_q     <= q_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign q       = q_q;
  assign q_valid = valid_q;
  assign ovr     = ovr_q;

endmodule

// File: rtl/sipo_rx.sv
// Serial-in / parallel-out receiver: start bit (1), W data bits LSB-first, optional even
// parity bit. Completed words go to a one-entry valid/ready buffer; reception never stalls.
// Ports: clk, rst_ (async active-low), si/sv (serial bit + valid), q/q_valid/q_ready (output
//        word handshake), ovr (frame dropped, buffer full), perr (parity mismatch pulse).
// Build option: define SIPO_RX_PARITY_EN to add the parity bit and check; otherwise perr=0.
module sipo_rx
  import sipo_rx_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         si,
  input  logic         sv,
  output logic [W-1:0] q,
  output logic         q_valid,
  input  logic         q_ready,
  output logic         ovr,
  output logic         perr
);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    shreg_q, shreg_d;
  logic            done;

`ifdef SIPO_RX_PARITY_EN
  logic perr_q, perr_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    done    = 1'b0;
`ifdef SIPO_RX_PARITY_EN
    perr_d  = 1'b0;
`endif
    if (sv) begin
      case (state_q)
        StIdle: begin
          if (si) begin
            state_d = StData;
            cnt_d   = '0;
            shreg_d = '0;
          end
        end
        StData: begin
          for (int unsigned i = 0; i < W; i++) begin
            if (cnt_q == CntW'(i)) shreg_d[i] = si;
          end
          if (cnt_q == CntW'(W - 1)) begin
            cnt_d = '0;
`ifdef SIPO_RX_PARITY_EN
            state_d = StPar;
`else
            state_d = StIdle;
            done    = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
`ifdef SIPO_RX_PARITY_EN
        StPar: begin
          state_d = StIdle;
          // Even parity: data bits plus parity bit must XOR to zero.
          if ((^{shreg_q, si}) == 1'b0) done = 1'b1;
          else perr_d = 1'b1;
        end
`endif
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

`ifdef SIPO_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) perr_q <= 1'b0;
    else       perr_q <= perr_d;
  end
  assign perr = perr_q;
`else
  assign perr = 1'b0;
`endif

  sipo_rx_obuf #(
    .W(W)
  ) u_obuf (
    .clk    (clk),
    .rst_   (rst_),
    .load   (done),
    .data   (shreg_d),
    .ready  (q_ready),
    .q      (q),
    .q_valid(q_valid),
    .ovr    (ovr)
  );

endmodule

// File: tb/tb_sipo_rx.sv
module tb_sipo_rx;
  import sipo_rx_pkg::*;

  localparam int unsigned W = 4;
`ifdef SIPO_RX_PARITY_EN
  localparam int FrameLen = W + 2;
  localparam bit ParEn    = 1'b1;
`else
  localparam int FrameLen = W + 1;
  localparam bit ParEn    = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_ = 1'b1;
  logic         si = 1'b0;
  logic         sv = 1'b0;
  logic         q_ready = 1'b0;
  logic [W-1:0] q;
  logic         q_valid, ovr, perr;

  int  n_checks = 0;
  int  n_err    = 0;
  bit  cmp_en   = 1'b0;

  sipo_rx #(.W(W)) dut (
    .clk    (clk),
    .rst_   (rst_),
    .si     (si),
    .sv     (sv),
    .q      (q),
    .q_valid(q_valid),
    .q_ready(q_ready),
    .ovr    (ovr),
    .perr   (perr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collect the frame as a list of bits, decode when complete.
  logic [W-1:0] m_q = '0;
  bit           m_valid = 1'b0, m_ovr = 1'b0, m_perr = 1'b0;
  initial begin
    bit           fb[$];
    bit           done, good;
    int           ones;
    logic [W-1:0] w;
    forever begin
      @(posedge clk or negedge rst_);
      if (!rst_) begin
        fb.delete();
        m_q = '0; m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
      end else begin
        m_ovr = 1'b0; m_perr = 1'b0; done = 1'b0; good = 1'b0; w = '0;
        if (sv && (fb.size() > 0 || si)) fb.push_back(si);
        if (fb.size() == FrameLen) begin
          ones = 0;
          for (int i = 1; i < FrameLen; i++) ones += int'(fb[i]);
          for (int i = 1; i <= int'(W); i++) w = w + (W'(fb[i]) << (i - 1));
          good = !ParEn || (ones % 2 == 0);
          done = 1'b1;
          fb.delete();
        end
        if (done && good) begin
          if (!m_valid || q_ready) begin
            m_q = w; m_valid = 1'b1;
          end else begin
            m_ovr = 1'b1;
          end
        end else begin
          if (done) m_perr = 1'b1;
          if (m_valid && q_ready) m_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    wait (cmp_en);
    forever begin
      @(negedge clk);
      chk("cyc_q_valid", q_valid, m_valid);
      chk("cyc_q", q, m_q);
      chk("cyc_ovr", ovr, m_ovr);
      chk("cyc_perr", perr, m_perr);
    end
  end

  // Inputs change 1 time unit after a rising edge and are sampled on the next one.
  task automatic send_bit(input logic b);
    sv = 1'b1; si = b;
    @(posedge clk); #1;
    sv = 1'b0; si = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Start bit, data LSB-first, then (parity build) parity = ^word ^ flip.
  // rdy_last raises q_ready only for the edge that samples the final bit.
  task automatic send_frame(input logic [W-1:0] word, input bit flip, input bit rdy_last);
    logic [W-1:0] wv;
    wv = word;
    send_bit(1'b1);
    for (int i = 0; i < int'(W); i++) begin
      if (!ParEn && i == int'(W) - 1 && rdy_last) q_ready = 1'b1;
      send_bit(wv[i]);
    end
    if (ParEn) begin
      if (rdy_last) q_ready = 1'b1;
      send_bit((^wv) ^ flip);
    end
    if (rdy_last) q_ready = 1'b0;
  endtask

  task automatic par_bit_if_needed(input logic [W-1:0] word);
    logic [W-1:0] wv;
    wv = word;
    if (ParEn) send_bit(^wv);
  endtask

  initial begin
    #2 rst_ = 1'b0;
    cmp_en = 1'b1;
    idle(2);
    chk("rst_q", q, 0);
    chk("rst_q_valid", q_valid, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_perr", perr, 0);
    rst_ = 1'b1;
    idle(1);

    // Basic frame 1,0,1,1 -> 4'hD, visible one clock after the last bit.
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    if (ParEn) send_bit(1'b1);
    chk("t1_before_last", q_valid, 0);
    if (ParEn) par_bit_if_needed(4'hD);
    else send_bit(1'b1);
    chk("t1_q", q, 4'hD);
    chk("t1_q_valid", q_valid, 1);
    q_ready = 1'b1;
    idle(1);
    q_ready = 1'b0;
    chk("t1_consumed", q_valid, 0);

    // Same frame with a 3-cycle sv=0 gap between data bits 2 and 3.
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("t2_gap_hold", q_valid, 0);
    end
    send_bit(1'b1);
    if (ParEn) send_bit(1'b1);
    chk("t2_before_last", q_valid, 0);
    if (ParEn) par_bit_if_needed(4'hD);
    else send_bit(1'b1);
    chk("t2_q", q, 4'hD);
    chk("t2_q_valid", q_valid, 1);
    q_ready = 1'b1; idle(1); q_ready = 1'b0;

    // Back-pressure: 3 then A back-to-back, A must be dropped with one ovr pulse.
    send_frame(4'h3, 1'b0, 1'b0);
    chk("t3_first", q, 4'h3);
    chk("t3_first_ovr", ovr, 0);
    send_frame(4'hA, 1'b0, 1'b0);
    chk("t3_hold_q", q, 4'h3);
    chk("t3_ovr_pulse", ovr, 1);
    idle(1);
    chk("t3_ovr_single", ovr, 0);
    chk("t3_still_valid", q_valid, 1);
    q_ready = 1'b1; idle(1); q_ready = 1'b0;
    chk("t3_drop", q_valid, 0);
    chk("t3_keep_q", q, 4'h3);
    send_frame(4'h5, 1'b0, 1'b0);
    chk("t3_next_q", q, 4'h5);
    chk("t3_next_valid", q_valid, 1);

    // Completion on the same edge as a consume: new word replaces old, no overrun.
    send_frame(4'h9, 1'b0, 1'b1);
    chk("t6_q", q, 4'h9);
    chk("t6_q_valid", q_valid, 1);
    chk("t6_ovr", ovr, 0);
    q_ready = 1'b1; idle(1); q_ready = 1'b0;

    // Reset after 2 data bits; partial frame must vanish.
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    rst_ = 1'b0;
    idle(2);
    chk("t4_rst_q", q, 0);
    chk("t4_rst_valid", q_valid, 0);
    rst_ = 1'b1;
    send_bit(1'b0);
    send_bit(1'b0);
    chk("t4_no_stale", q_valid, 0);
    send_frame(4'h6, 1'b0, 1'b0);
    chk("t4_q", q, 4'h6);
    chk("t4_q_valid", q_valid, 1);
    q_ready = 1'b1; idle(1); q_ready = 1'b0;

    // Parity: correct parity delivers, wrong parity pulses perr and drops.
    send_frame(4'hD, 1'b0, 1'b0);
    chk("t5_good_q", q, 4'hD);
    chk("t5_good_valid", q_valid, 1);
    chk("t5_good_perr", perr, 0);
    q_ready = 1'b1; idle(1); q_ready = 1'b0;
    send_frame(4'hD, 1'b1, 1'b0);
    chk("t5_bad_perr", perr, ParEn ? 1 : 0);
    chk("t5_bad_valid", q_valid, ParEn ? 0 : 1);
    idle(1);
    chk("t5_perr_single", perr, 0);
    q_ready = 1'b1; idle(2); q_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
